// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// master = producer/consumer side, slave = the adder.
interface pipelined_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry, overflow
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, carry, overflow
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor. Each stage resolves one SEG_WIDTH-bit
// ripple segment and registers its carry for the next stage. Valid/ready
// handshake with per-stage bubble collapsing; the last stage is the output
// register.
module pipelined_adder #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SEG_WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_adder_if.slave bus
);

  localparam int unsigned STAGES = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
  localparam int unsigned LAST   = STAGES - 1;

  typedef logic [WIDTH-1:0] word_t;

  // Stage registers
  logic  v_q [STAGES];
  logic  c_q [STAGES];
  word_t a_q [STAGES];
  word_t b_q [STAGES];
  word_t s_q [STAGES];
  logic  ovf_q;

  // Stage next-state
  logic  v_d [STAGES];
  word_t a_d [STAGES];
  word_t b_d [STAGES];
  word_t s_d [STAGES];
  logic  c_d [STAGES];
  logic  ovf_d;

  // Segment-adder operands (completed low sum bits and incoming carry)
  word_t s_src [STAGES];
  logic  c_src [STAGES];

  logic [STAGES-1:0] load;

  // Adds segment idx of x+y+ci and merges it into the partial sum s.
  // Masked full-width arithmetic keeps segment bounds constant per stage
  // while letting the narrower last segment take its carry at bit WIDTH.
  function automatic logic [WIDTH:0] seg_add(
    input word_t       x,
    input word_t       y,
    input word_t       s,
    input logic        ci,
    input int unsigned idx
  );
    logic [WIDTH:0] m;
    logic [WIDTH:0] t;
    logic [WIDTH:0] sh;
    int unsigned    lo;
    int unsigned    hi;
    lo = idx * SEG_WIDTH;
    hi = (lo + SEG_WIDTH > WIDTH) ? WIDTH : lo + SEG_WIDTH;
    m  = ({{WIDTH{1'b0}}, 1'b1} << hi) - ({{WIDTH{1'b0}}, 1'b1} << lo);
    t  = ({1'b0, x} & m) + ({1'b0, y} & m) + ({{WIDTH{1'b0}}, ci} << lo);
    sh = t >> hi;
    return {sh[0], (s & ~m[WIDTH-1:0]) | (t[WIDTH-1:0] & m[WIDTH-1:0])};
  endfunction

  // Advance chain: a stage loads when empty or when the stage after it loads.
  always_comb begin : p_load
    logic run;
    load = '0;
    run  = bus.out_ready;
    for (int unsigned k = 0; k < STAGES; k++) begin
      run             = run | ~v_q[LAST-k];
      load[LAST-k]    = run;
    end
  end

  // Per-stage operand selection and segment addition.
  always_comb begin
    v_d[0]   = bus.in_valid;
    a_d[0]   = bus.a;
    b_d[0]   = bus.sub ? ~bus.b : bus.b;
    s_src[0] = '0;
    c_src[0] = bus.sub ^ bus.c_in;
    for (int unsigned k = 1; k < STAGES; k++) begin
      v_d[k]   = v_q[k-1];
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      {c_d[k], s_d[k]} = seg_add(a_d[k], b_d[k], s_src[k], c_src[k], k);
    end
    ovf_d = (a_d[LAST][WIDTH-1] == b_d[LAST][WIDTH-1]) &&
            (s_d[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);
  end

  // Stage registers; data only captured for valid entries so the output
  // stage keeps its last result while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          v_q[k] <= v_d[k];
          if (v_d[k]) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
            c_q[k] <= c_d[k];
          end
        end
      end
      if (load[LAST] && v_d[LAST]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = v_q[LAST];
  assign bus.sum       = s_q[LAST];
  assign bus.carry     = c_q[LAST];
  assign bus.overflow  = ovf_q;

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined WIDTH-bit adder/subtractor built from SEG_WIDTH-bit ripple segments.
- One segment resolves per pipeline stage, and the carry is registered between stages.
- Valid/ready handshake on input and output, with per-stage bubble collapsing.
- Successor to the single-bit full adder; serves as the arithmetic datapath element for wider units.

Parameters:
- WIDTH, 32, operand and result width in bits (>=1).
- SEG_WIDTH, 8, bits resolved per stage (1..WIDTH).
- STAGES (derived, localparam): ceil(WIDTH/SEG_WIDTH). The last segment holds WIDTH-(STAGES-1)*SEG_WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0: a+b+c_in; 1: a-b-c_in
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- carry  output  1  raw adder carry-out (in sub mode: 1 = no borrow)
- overflow  output  1  signed two's-complement overflow

Behaviour:
- Reset is asynchronous and active-low; no clock is needed to enter reset. While rst_n=0, every stage valid=0, out_valid=0, sum=0, carry=0, overflow=0. in_ready=1 from the first cycle after reset release.
- Operation: b_eff = sub ? ~b : b; cin_eff = sub ? ~c_in : c_in; result = a + b_eff + cin_eff.
  - carry = bit WIDTH of that sum.
  - overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- Stage i (0..STAGES-1) register set:
  - valid_i, sub_i
  - carry_i (carry out of segment i)
  - completed low sum bits [0 .. (i+1)*SEG_WIDTH-1]
  - unresolved upper bits of a and b_eff
  - a[MSB] and b_eff[MSB] for overflow
- Stage 0 adds segment 0 of a/b_eff with cin_eff. Stage i>0 adds segment i with carry_{i-1}. No segment ever sees more than one carry hop per cycle.
- Stage STAGES-1 is the output register: sum, carry, overflow and out_valid are driven directly from flops, with no combinational path from the inputs.
- Advance rule, evaluated per stage:
  - Output stage loads when !valid_last || out_ready.
  - Stage i loads when !valid_i || load_{i+1}.
  - in_ready = load_0. This is combinational from out_ready through the chain; no path from in_valid.
- Bubble collapsing: a stage holding valid=0 always loads, so gaps close while downstream is stalled.
- Transfer occurs on an edge with in_valid&&in_ready (accept) or out_valid&&out_ready (retire).
- Latency: with no stall, an operand accepted at edge k appears with out_valid=1 after edge k+STAGES-1. This is STAGES register stages, i.e. STAGES-1 cycles after acceptance. Throughput is 1 per cycle.
- Capacity: STAGES results in flight. in_ready=0 only when all stages are valid and out_ready=0.
- Simultaneous accept and retire with a full pipeline: both happen, and occupancy is unchanged.
- Stall: while out_valid && !out_ready, sum/carry/overflow/out_valid hold stable (AXI-style). in_valid may drop without effect on data already in flight.
- Ordering: results emerge strictly in acceptance order. No reordering or drop.
- Data registers of invalid stages are don't-care except the output stage, which holds its last value.
- Reset mid-operation: all in-flight results are discarded and the next out_valid is for an operand accepted after reset release.
- STAGES=1 (SEG_WIDTH>=WIDTH): a single registered adder with identical handshake.
- Non-divisible WIDTH: the last segment is narrower. carry is taken at bit WIDTH, not at the segment boundary.

Test Plan:
- WIDTH=32, SEG_WIDTH=8: a=0xFFFFFFFF, b=0x00000001, c_in=0, sub=0, out_ready=1 -> sum=0x00000000, carry=1, overflow=0, out_valid exactly 3 cycles after accept.
- Signed overflow and subtract: a=0x7FFFFFFF+b=0x1 -> sum=0x80000000, carry=0, overflow=1. Then sub=1: a=5, b=7, c_in=0 -> sum=0xFFFFFFFE, carry=0, overflow=0. Then sub=1: a=0x80000000, b=1 -> sum=0x7FFFFFFF, carry=1, overflow=1.
- Back-pressure: stream 10 random pairs with in_valid=1 and hold out_ready=0 for 6 cycles -> in_ready falls after 4 accepts, output stays stable. On release, all 10 results retire in order, matching a golden model, one per cycle.
- Bubbles: accept one item, idle 2 cycles, accept another, with out_ready=0 -> both stages collapse adjacent; releasing out_ready yields them on consecutive cycles.
- Reset mid-flight: pulse rst_n low asynchronously (mid-cycle) with 3 items in flight -> out_valid, sum, carry and overflow go 0 immediately. No stale result appears; the next accepted a=1, b=2 yields sum=3.
- WIDTH=10, SEG_WIDTH=4 (STAGES=3): a=0x3FF, b=0x001 -> sum=0x000, carry=1 after 2 cycles. a=0x00F, b=0x001 -> sum=0x010, carry=0, confirming carry across the segment boundary.
